i2c_slave_responder: RTL and testbench

- Synthesizable I2C target (slave) with a fixed 7-bit address. It is the responder end of the bus driven by the iicmb_m_wb multi-bus controller.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Delivers written bytes on a valid pulse; sources read bytes through a request/valid handshake. No clock stretching.
- Plugs into the proj benches as a hardware alternative to the i2c_if slave BFM.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_sync_edge.sv | 38 +++
 rtl/i2c_slave_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        IGNORE
    } i2c_slave_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-stage synchronizer with a history flop; emits registered rise/fall pulses
// aligned with the updated level.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            hist_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & hist_q;
        end
    end

    assign level = hist_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a fixed address: delivers written bytes on wr_valid and sources
// read bytes through an rd_req/rd_valid handshake. No clock stretching.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter int unsigned                I2C_ADDR_WIDTH = 7,
    parameter int unsigned                I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]  SLAVE_ADDR     = 7'h22,
    parameter int unsigned                SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data,
    output logic                      wr_valid,
    output logic                      rd_req,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data,
    input  logic                      rd_valid,
    output logic                      start_det,
    output logic                      stop_det,
    output logic                      busy,
    output logic                      rd_underrun
);

    localparam int unsigned SW = (I2C_ADDR_WIDTH + 1 > I2C_DATA_WIDTH) ?
                                 I2C_ADDR_WIDTH + 1 : I2C_DATA_WIDTH;
    localparam int unsigned CW = $clog2(SW + 1);
    localparam int unsigned DW = I2C_DATA_WIDTH;
    localparam logic [CW-1:0] ADDR_BITS = CW'(I2C_ADDR_WIDTH + 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(I2C_DATA_WIDTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (scl_i),
        .level(scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda_sync (
        .clk  (clk),
        .rst  (rst),
        .raw  (sda_i),
        .level(sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    i2c_slave_state_t state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic [DW-1:0]    tx_q, tx_d;
    i2c_op_t          rw_q, rw_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;
    logic [DW-1:0]    rd_buf_q, rd_buf_d;
    logic             rd_buf_vld_q, rd_buf_vld_d;
    logic             rd_win_q, rd_win_d;
    logic             sda_q, sda_d;
    logic             busy_q, busy_d;
    logic             wr_valid_q, wr_valid_d;
    logic             rd_req_q, rd_req_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             under_q, under_d;

    logic             start_cond, stop_cond;
    logic             rd_capture, open_win, do_load;
    logic [DW-1:0]    load_byte;

    assign start_cond = sda_fall & scl_lvl;
    assign stop_cond  = sda_rise & scl_lvl;
    assign rd_capture = rd_win_q & rd_valid;
    // A same-cycle rd_valid still counts at the load edge.
    assign load_byte  = rd_capture ? rd_data : rd_buf_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        rw_d         = rw_q;
        wr_data_d    = wr_data_q;
        rd_buf_d     = rd_buf_q;
        rd_buf_vld_d = rd_buf_vld_q;
        rd_win_d     = rd_win_q;
        sda_d        = sda_q;
        busy_d       = busy_q;
        wr_valid_d   = 1'b0;
        rd_req_d     = 1'b0;
        start_d      = 1'b0;
        stop_d       = 1'b0;
        under_d      = 1'b0;
        open_win     = 1'b0;
        do_load      = 1'b0;

        if (rd_capture) begin
            rd_buf_d     = rd_data;
            rd_buf_vld_d = 1'b1;
        end

        unique case (state_q)
            IDLE, IGNORE: ;
            ADDR: begin
                if (scl_rise && bit_cnt_q < ADDR_BITS) begin
                    shift_d   = {shift_q[SW-2:0], sda_lvl};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
                if (scl_fall && bit_cnt_q == ADDR_BITS) begin
                    bit_cnt_d = '0;
                    if (shift_q[I2C_ADDR_WIDTH:1] == SLAVE_ADDR) begin
                        sda_d   = I2C_ACK;
                        rw_d    = i2c_op_t'(shift_q[0]);
                        state_d = ADDR_ACK;
                    end else begin
                        sda_d   = I2C_NACK;
                        state_d = IGNORE;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_rise && rw_q == READ) open_win = 1'b1;
                if (scl_fall) begin
                    if (rw_q == READ) begin
                        do_load = 1'b1;
                    end else begin
                        sda_d     = I2C_NACK;
                        bit_cnt_d = '0;
                        state_d   = WDATA;
                    end
                end
            end
            WDATA: begin
                if (scl_rise && bit_cnt_q < DATA_BITS) begin
                    shift_d   = {shift_q[SW-2:0], sda_lvl};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == DATA_BITS - CW'(1)) begin
                        wr_data_d  = {shift_q[DW-2:0], sda_lvl};
                        wr_valid_d = 1'b1;
                    end
                end
                if (scl_fall && bit_cnt_q == DATA_BITS) begin
                    sda_d     = I2C_ACK;
                    bit_cnt_d = '0;
                    state_d   = WACK;
                end
            end
            WACK: begin
                if (scl_fall) begin
                    sda_d   = I2C_NACK;
                    state_d = WDATA;
                end
            end
            RDATA: begin
                if (scl_fall) begin
                    if (bit_cnt_q == DATA_BITS) begin
                        sda_d     = I2C_NACK;
                        bit_cnt_d = '0;
                        state_d   = RACK;
                    end else begin
                        sda_d     = tx_q[DW-1];
                        tx_d      = {tx_q[DW-2:0], 1'b1};
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            RACK: begin
                if (scl_rise) begin
                    if (sda_lvl == I2C_ACK) open_win = 1'b1;
                    else state_d = IGNORE;
                end
                if (scl_fall && rd_win_q) do_load = 1'b1;
            end
        endcase

        if (open_win) begin
            rd_req_d     = 1'b1;
            rd_win_d     = 1'b1;
            rd_buf_d     = '1;
            rd_buf_vld_d = 1'b0;
        end

        // First bit leaves on the load edge; the rest shift out of tx.
        if (do_load) begin
            sda_d        = load_byte[DW-1];
            tx_d         = {load_byte[DW-2:0], 1'b1};
            under_d      = ~(rd_capture | rd_buf_vld_q);
            rd_win_d     = 1'b0;
            rd_buf_d     = '1;
            rd_buf_vld_d = 1'b0;
            bit_cnt_d    = CW'(1);
            state_d      = RDATA;
        end

        if (stop_cond) begin
            stop_d       = 1'b1;
            busy_d       = 1'b0;
            sda_d        = I2C_NACK;
            rd_win_d     = 1'b0;
            rd_buf_vld_d = 1'b0;
            under_d      = 1'b0;
            state_d      = IDLE;
        end else if (start_cond) begin
            start_d      = 1'b1;
            busy_d       = 1'b1;
            sda_d        = I2C_NACK;
            rd_win_d     = 1'b0;
            rd_buf_vld_d = 1'b0;
            under_d      = 1'b0;
            bit_cnt_d    = '0;
            state_d      = ADDR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= '1;
            rw_q         <= WRITE;
            wr_data_q    <= '0;
            rd_buf_q     <= '1;
            rd_buf_vld_q <= 1'b0;
            rd_win_q     <= 1'b0;
            sda_q        <= 1'b1;
            busy_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            under_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            rw_q         <= rw_d;
            wr_data_q    <= wr_data_d;
            rd_buf_q     <= rd_buf_d;
            rd_buf_vld_q <= rd_buf_vld_d;
            rd_win_q     <= rd_win_d;
            sda_q        <= sda_d;
            busy_q       <= busy_d;
            wr_valid_q   <= wr_valid_d;
            rd_req_q     <= rd_req_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            under_q      <= under_d;
        end
    end

    assign sda_o       = sda_q;
    assign wr_data     = wr_data_q;
    assign wr_valid    = wr_valid_q;
    assign rd_req      = rd_req_q;
    assign start_det   = start_q;
    assign stop_det    = stop_q;
    assign busy        = busy_q;
    assign rd_underrun = under_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master drives the bus while a
// scoreboard checks every DUT event pulse against the expected sequence.
module tb_i2c_slave_responder;

    localparam int EV_START = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_WR    = 2;
    localparam int EV_REQ   = 3;
    localparam int EV_UNDER = 4;

    typedef struct {
        int kind;
        int data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_o;
    logic [7:0] wr_data;
    logic       wr_valid, rd_req, start_det, stop_det, busy, rd_underrun;
    logic [7:0] rd_data;
    logic       rd_valid;
    wire        sda_bus = sda_m & sda_o;

    int         total = 0;
    int         bad = 0;
    evt_t       exp_q[$];
    logic [7:0] rd_vals[$];
    bit         supply_en = 1'b0;

    i2c_slave_responder dut (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy),
        .rd_underrun(rd_underrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic void expect_evt(input int k, input int d);
        evt_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    function automatic void see(input int k, input int d);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL event: got kind %0d data %0h, required no event", k, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d) begin
                bad++;
                $display("FAIL event: got kind %0d data %0h, required kind %0d data %0h",
                         k, d, e.kind, e.data);
            end
        end
    endfunction

    // Monitor: every output pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (start_det)   see(EV_START, 0);
            if (stop_det)    see(EV_STOP, 0);
            if (wr_valid)    see(EV_WR, int'(wr_data));
            if (rd_req)      see(EV_REQ, 0);
            if (rd_underrun) see(EV_UNDER, 0);
        end
    end

    // Read-data source: answers rd_req two clocks later when enabled.
    initial begin
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_req && supply_en && rd_vals.size() > 0) begin
                @(negedge clk);
                @(negedge clk);
                rd_data  = rd_vals.pop_front();
                rd_valid = 1'b1;
                @(negedge clk);
                rd_valid = 1'b0;
            end
        end
    end

    task automatic clock_bit(input logic b, output logic s);
        tick(5);
        sda_m = b;
        tick(5);
        scl_m = 1'b1;
        tick(5);
        s = sda_bus;
        tick(5);
        scl_m = 1'b0;
    endtask

    task automatic m_start();
        expect_evt(EV_START, 0);
        tick(5);
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
    endtask

    task automatic m_rstart();
        expect_evt(EV_START, 0);
        tick(5);
        sda_m = 1'b1;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
    endtask

    task automatic m_stop();
        expect_evt(EV_STOP, 0);
        tick(5);
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b1;
        tick(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] b;

        scl_m = 1'b1;
        sda_m = 1'b1;
        rst   = 1'b1;
        tick(3);
        check("reset sda_o", sda_o, 1);
        check("reset busy", busy, 0);
        check("reset wr_data", wr_data, 0);
        check("reset pulses", {wr_valid, rd_req, start_det, stop_det, rd_underrun}, 0);
        rst = 1'b0;
        tick(5);

        // Write 32 bytes to 0x22
        m_start();
        write_byte(8'h44, ack);
        check("t1 addr ack", ack, 0);
        check("t1 busy", busy, 1);
        for (int i = 0; i < 32; i++) begin
            expect_evt(EV_WR, i);
            write_byte(8'(i), ack);
            check("t1 data ack", ack, 0);
        end
        m_stop();
        check("t1 busy after stop", busy, 0);
        check("t1 sda released", sda_o, 1);

        // Read 32 bytes, NACK the last
        supply_en = 1'b1;
        for (int i = 0; i < 32; i++) rd_vals.push_back(8'(100 + i));
        m_start();
        expect_evt(EV_REQ, 0);
        write_byte(8'h45, ack);
        check("t2 addr ack", ack, 0);
        for (int i = 0; i < 32; i++) begin
            if (i < 31) expect_evt(EV_REQ, 0);
            read_byte(i == 31, b);
            check("t2 read byte", b, 100 + i);
        end
        tick(6);
        check("t2 sda after nack", sda_o, 1);
        m_stop();
        supply_en = 1'b0;

        // Wrong address: no ACK anywhere, stays busy until STOP
        m_start();
        write_byte(8'h46, ack);
        check("t3 addr nack", ack, 1);
        write_byte(8'h55, ack);
        check("t3 data nack", ack, 1);
        check("t3 busy", busy, 1);
        m_stop();

        // Write then repeated START and read
        m_start();
        write_byte(8'h44, ack);
        check("t4 addr ack", ack, 0);
        expect_evt(EV_WR, 8'h78);
        write_byte(8'h78, ack);
        check("t4 data ack", ack, 0);
        supply_en = 1'b1;
        rd_vals.push_back(8'hA5);
        m_rstart();
        expect_evt(EV_REQ, 0);
        write_byte(8'h45, ack);
        check("t4 read addr ack", ack, 0);
        read_byte(1'b1, b);
        check("t4 read byte", b, 8'hA5);
        m_stop();
        supply_en = 1'b0;

        // Read with no rd_valid: underrun, bus sees 0xFF
        m_start();
        expect_evt(EV_REQ, 0);
        expect_evt(EV_UNDER, 0);
        write_byte(8'h45, ack);
        check("t5 addr ack", ack, 0);
        read_byte(1'b1, b);
        check("t5 underrun byte", b, 8'hFF);
        m_stop();

        // Reset in the middle of a write byte
        m_start();
        write_byte(8'h44, ack);
        check("t6 addr ack", ack, 0);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        tick(5);
        sda_m = 1'b1;
        tick(5);
        scl_m = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("t6 sda in reset", sda_o, 1);
        check("t6 busy in reset", busy, 0);
        check("t6 wr_valid in reset", wr_valid, 0);
        tick(3);
        rst = 1'b0;
        tick(3);
        scl_m = 1'b0;
        tick(5);
        m_stop();
        m_start();
        write_byte(8'h44, ack);
        check("t6 re-addr ack", ack, 0);
        expect_evt(EV_WR, 8'h3C);
        write_byte(8'h3C, ack);
        check("t6 data ack", ack, 0);
        m_stop();
        check("t6 wr_data", wr_data, 8'h3C);

        tick(20);
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
